udp_ingress_arbiter: RTL and testbench
======================================

# udp_ingress_arbiter

Frame-granular round-robin arbiter that shares the single framed write port of the UDP parsing pipeline (`wr_en`/`wr_sof`/`wr_eof`/`data_din`/`full` of `udp_top`) between NUM_PORTS upstream byte FIFOs. Once a source's SOF byte is granted, the whole frame is forwarded without interleaving. Malformed heads (no SOF) are discarded. Runaway frames longer than MAX_FRAME are truncated with a forced EOF, and the source is drained to its EOF.

## Interface
- NUM_PORTS, 2: number of requesting sources; must be ≥ 2.
- DATA_WIDTH, 8: byte width; must match the pipeline FIFO width.
- MAX_FRAME, 2048: maximum bytes forwarded per frame, including SOF and EOF bytes.
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high; clears all state.
- in_empty  in  NUM_PORTS  per-source FIFO empty.
- in_dout  in  NUM_PORTS*DATA_WIDTH  per-source head byte; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_sof  in  NUM_PORTS  head-byte SOF flag.
- in_eof  in  NUM_PORTS  head-byte EOF flag.
- in_rd_en  out  NUM_PORTS  per-source pop; at most one bit high in any cycle.
- wr_en  out  1  write strobe to the pipeline.
- wr_sof  out  1  SOF qualifier for the written byte.
- wr_eof  out  1  EOF qualifier for the written byte.
- data_din  out  DATA_WIDTH  written byte.
- full  in  1  pipeline input FIFO full.
- busy  out  1  high in XFER or DRAIN.
- grant_id  out  max(1,$clog2(NUM_PORTS))  currently or last granted source.
- frame_count  out  16  frames completed to the pipeline, normal or truncated; saturates at 0xFFFF.
- drop_count  out  16  head bytes discarded in IDLE; saturates.
- trunc_count  out  16  frames truncated at MAX_FRAME; saturates.

## Operation
- Source FIFOs are first-word-fall-through: in_dout, in_sof and in_eof are valid whenever in_empty=0. Asserting in_rd_en pops at the clock edge.
- State machine: IDLE, XFER, DRAIN. Registers: state, grant, rr_ptr, beat_cnt (width $clog2(MAX_FRAME+1)), and the three counters.
- IDLE
  - Candidate: first non-empty source searching rr_ptr, rr_ptr+1, … mod NUM_PORTS.
  - Candidate head has in_sof=1: grant←candidate, beat_cnt←0, next state XFER. No pop this cycle.
  - Candidate head has in_sof=0: assert in_rd_en[candidate] (discard), drop_count+1, stay IDLE. rr_ptr is unchanged.
  - No candidate: nothing happens.
  - wr_en=0 in IDLE.
- XFER
  - beat = !in_empty[grant] && !full.
  - On a beat: in_rd_en[grant]=wr_en=1, data_din=in_dout[grant], beat_cnt+1.
  - wr_sof = in_sof[grant] && beat_cnt==0. SOF flags on later bytes are forwarded with wr_sof=0.
  - wr_eof = in_eof[grant] || beat_cnt==MAX_FRAME-1.
  - Beat with in_eof=1: frame_count+1, rr_ptr←grant+1 mod NUM_PORTS, next state IDLE.
  - Beat with beat_cnt==MAX_FRAME-1 and in_eof=0: forced EOF; frame_count+1, trunc_count+1, next state DRAIN.
- DRAIN
  - in_rd_en[grant] = !in_empty[grant]; wr_en=0. `full` is ignored.
  - When a popped byte has in_eof=1: rr_ptr←grant+1 mod NUM_PORTS, next state IDLE.
- Combinational outputs: data_din, wr_sof and wr_eof are driven 0 whenever wr_en=0.
- Counters saturate at 0xFFFF and do not wrap.

## Timing
- Reset values: state IDLE, grant 0, rr_ptr 0, beat_cnt 0, all counters 0. Therefore in_rd_en=0, wr_en=0, wr_sof=0, wr_eof=0, data_din=0, busy=0, grant_id=0.
- Reset asserted mid-frame: immediate return to IDLE with no EOF emitted. The downstream pipeline shares the reset, so no partial frame survives.
- in_rd_en, wr_en and the write data path are combinational from state, in_empty and full; there is no added write latency.
- Arbitration latency: grant decided in the IDLE cycle; earliest first write is the next cycle.
- Gap between frames: at least one IDLE cycle, so a granted source sustains 1 byte/cycle within a frame.
- full=1 in XFER: no pop and no write; byte and beat_cnt hold; state held indefinitely.
- Source empty mid-frame: XFER waits. No other source is serviced and there is no timeout.
- Single-byte frame (SOF and EOF on the same byte): one XFER beat with wr_sof=wr_eof=1.
- MAX_FRAME=1 case: the SOF byte also carries a forced EOF.
- Only the candidate chosen that cycle is examined in IDLE; other non-empty sources wait.

## Test plan
- Reset then idle: all outputs 0. Source 0 presents a 3-byte frame AA(sof),BB,CC(eof) -> write in cycles 2–4 with wr_sof only on AA and wr_eof only on CC; frame_count=1.
- Round-robin: sources 0 and 1 each hold two 2-byte frames -> pipeline order src0,src1,src0,src1 with no byte interleaving; grant_id toggles; each frame is followed by an IDLE cycle.
- Backpressure: hold full=1 for 5 cycles mid-frame -> wr_en=0 and in_rd_en=0 for those 5 cycles; byte order intact; no duplicated or lost bytes.
- Junk head: source 1 holds 2 non-SOF bytes then a valid frame -> 2 pops with wr_en=0; drop_count=2; the frame then forwards normally.
- Truncation: MAX_FRAME=4, source 0 sends a 7-byte frame -> 4 bytes written, 4th with wr_eof=1; remaining 3 bytes popped with wr_en=0; trunc_count=1, frame_count=1; next grant goes to source 1.
- Reset mid-XFER after 2 bytes -> next cycle busy=0, state IDLE, all counters 0, in_rd_en=0.

Source files
------------

// File: rtl/udp_ingress_arbiter.sv
// udp_ingress_arbiter
// Shares the single framed write port of the UDP pipeline between
// NUM_PORTS first-word-fall-through byte FIFOs. Arbitration is
// round-robin at frame granularity. Heads without SOF are discarded.
// Frames longer than MAX_FRAME receive a forced EOF, and the rest of
// the source frame is drained without being written.
module udp_ingress_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAME  = 2048
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_dout,
  input  logic [NUM_PORTS-1:0]            in_sof,
  input  logic [NUM_PORTS-1:0]            in_eof,
  output logic [NUM_PORTS-1:0]            in_rd_en,
  output logic                            wr_en,
  output logic                            wr_sof,
  output logic                            wr_eof,
  output logic [DATA_WIDTH-1:0]           data_din,
  input  logic                            full,
  output logic                            busy,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] grant_id,
  output logic [15:0]                     frame_count,
  output logic [15:0]                     drop_count,
  output logic [15:0]                     trunc_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = $clog2(MAX_FRAME + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [PW-1:0]   grant_r;
  logic [PW-1:0]   next_grant_s;
  logic [PW-1:0]   rr_ptr_r;
  logic [PW-1:0]   next_rr_s;
  logic [BW-1:0]   beat_cnt_r;
  logic [BW-1:0]   next_beat_s;
  logic [15:0]     frame_count_r;
  logic [15:0]     drop_count_r;
  logic [15:0]     trunc_count_r;

  logic                  cand_found_s;
  logic [PW-1:0]         cand_idx_s;
  logic [DATA_WIDTH-1:0] head_data_s;
  logic                  head_sof_s;
  logic                  head_eof_s;
  logic                  head_empty_s;
  logic                  last_beat_s;

  logic [NUM_PORTS-1:0]  rd_en_s;
  logic                  wr_en_s;
  logic                  wr_sof_s;
  logic                  wr_eof_s;
  logic [DATA_WIDTH-1:0] data_s;
  logic                  frame_inc_s;
  logic                  drop_inc_s;
  logic                  trunc_inc_s;

  // Saturating 16-bit increment; statistics stick at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    if (value == 16'hFFFF) begin
      return value;
    end else begin
      return value + 16'd1;
    end
  endfunction

  // Next source index after p, wrapping at NUM_PORTS.
  function automatic logic [PW-1:0] next_port(input logic [PW-1:0] p);
    if (p == PW'(NUM_PORTS - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // Granted source's head byte and flags.
  assign head_data_s  = in_dout[grant_r*DATA_WIDTH +: DATA_WIDTH];
  assign head_sof_s   = in_sof[grant_r];
  assign head_eof_s   = in_eof[grant_r];
  assign head_empty_s = in_empty[grant_r];
  assign last_beat_s  = (beat_cnt_r == BW'(MAX_FRAME - 1));

  // Round-robin candidate: first non-empty source at or after rr_ptr.
  always_comb begin
    cand_found_s = 1'b0;
    cand_idx_s   = {PW{1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      int idx;
      idx = int'(rr_ptr_r) + k;
      idx = (idx >= NUM_PORTS) ? (idx - NUM_PORTS) : idx;
      if (!cand_found_s && !in_empty[idx]) begin
        cand_found_s = 1'b1;
        cand_idx_s   = PW'(idx);
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // Next-state logic, pops, write path, and counter strobes.
  always_comb begin
    next_state_s = state_r;
    next_grant_s = grant_r;
    next_rr_s    = rr_ptr_r;
    next_beat_s  = beat_cnt_r;
    rd_en_s      = {NUM_PORTS{1'b0}};
    wr_en_s      = 1'b0;
    wr_sof_s     = 1'b0;
    wr_eof_s     = 1'b0;
    data_s       = {DATA_WIDTH{1'b0}};
    frame_inc_s  = 1'b0;
    drop_inc_s   = 1'b0;
    trunc_inc_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cand_found_s) begin
          if (in_sof[cand_idx_s]) begin
            // Grant without popping; the SOF byte is written next cycle.
            next_grant_s = cand_idx_s;
            next_beat_s  = {BW{1'b0}};
            next_state_s = ST_XFER;
          end else begin
            // A head without SOF cannot start a frame, so discard it.
            rd_en_s[cand_idx_s] = 1'b1;
            drop_inc_s          = 1'b1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (!head_empty_s && !full) begin
          rd_en_s[grant_r] = 1'b1;
          wr_en_s          = 1'b1;
          data_s           = head_data_s;
          wr_sof_s         = head_sof_s && (beat_cnt_r == {BW{1'b0}});
          wr_eof_s         = head_eof_s || last_beat_s;
          next_beat_s      = beat_cnt_r + BW'(1);
          if (head_eof_s) begin
            frame_inc_s  = 1'b1;
            next_rr_s    = next_port(grant_r);
            next_state_s = ST_IDLE;
          end else if (last_beat_s) begin
            // Runaway frame: forced EOF already written, drain the rest.
            frame_inc_s  = 1'b1;
            trunc_inc_s  = 1'b1;
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_XFER;
          end
        end else begin
          // Source empty or pipeline full: hold the byte and the count.
          next_state_s = ST_XFER;
        end
      end
      ST_DRAIN: begin
        if (!head_empty_s) begin
          rd_en_s[grant_r] = 1'b1;
          if (head_eof_s) begin
            next_rr_s    = next_port(grant_r);
            next_state_s = ST_IDLE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end else begin
          next_state_s = ST_DRAIN;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      grant_r    <= {PW{1'b0}};
      rr_ptr_r   <= {PW{1'b0}};
      beat_cnt_r <= {BW{1'b0}};
    end else begin
      state_r    <= next_state_s;
      grant_r    <= next_grant_s;
      rr_ptr_r   <= next_rr_s;
      beat_cnt_r <= next_beat_s;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count_r <= 16'd0;
      drop_count_r  <= 16'd0;
      trunc_count_r <= 16'd0;
    end else begin
      if (frame_inc_s) begin
        frame_count_r <= sat_inc16(frame_count_r);
      end else begin
        frame_count_r <= frame_count_r;
      end
      if (drop_inc_s) begin
        drop_count_r <= sat_inc16(drop_count_r);
      end else begin
        drop_count_r <= drop_count_r;
      end
      if (trunc_inc_s) begin
        trunc_count_r <= sat_inc16(trunc_count_r);
      end else begin
        trunc_count_r <= trunc_count_r;
      end
    end
  end

  assign in_rd_en    = rd_en_s;
  assign wr_en       = wr_en_s;
  assign wr_sof      = wr_sof_s;
  assign wr_eof      = wr_eof_s;
  assign data_din    = data_s;
  assign busy        = (state_r != ST_IDLE);
  assign grant_id    = grant_r;
  assign frame_count = frame_count_r;
  assign drop_count  = drop_count_r;
  assign trunc_count = trunc_count_r;

endmodule

// File: tb/tb_udp_ingress_arbiter.sv
// Self-checking bench for udp_ingress_arbiter: bench-side source FIFOs,
// a frame-level reference model compared every cycle, directed
// scenarios with literal expectations, and a randomized run.
module tb_udp_ingress_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int MF = 4;
  localparam int GW = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     in_empty = '1;
  logic [N*W-1:0]   in_dout = '0;
  logic [N-1:0]     in_sof = '0;
  logic [N-1:0]     in_eof = '0;
  logic [N-1:0]     in_rd_en;
  logic             wr_en, wr_sof, wr_eof, busy;
  logic             full = 1'b0;
  logic [W-1:0]     data_din;
  logic [GW-1:0]    grant_id;
  logic [15:0]      frame_count, drop_count, trunc_count;

  udp_ingress_arbiter #(.NUM_PORTS(N), .DATA_WIDTH(W), .MAX_FRAME(MF)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout),
    .in_sof(in_sof), .in_eof(in_eof), .in_rd_en(in_rd_en), .wr_en(wr_en),
    .wr_sof(wr_sof), .wr_eof(wr_eof), .data_din(data_din), .full(full),
    .busy(busy), .grant_id(grant_id), .frame_count(frame_count),
    .drop_count(drop_count), .trunc_count(trunc_count)
  );

  always #5 clock = ~clock;

  // Entries are {sof, eof, data[7:0]}.
  logic [9:0] q    [N][$];
  logic [9:0] pend [N][$];
  logic [9:0] wlog [$];
  int         wcyc [$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  bit full_v = 1'b0;

  // Reference model: phase 0 = between frames, 1 = forwarding, 2 = discarding tail.
  int m_phase, m_grant, m_next, m_sent, m_frames, m_drops, m_truncs;

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_log(input string name, input int idx, input logic [9:0] exp);
    if (idx < wlog.size()) chk(name, 32'(wlog[idx]), 32'(exp));
    else chk(name, 32'hDEAD, 32'(exp));
  endtask

  task automatic chk_cyc(input string name, input int idx, input int exp);
    if (idx < wcyc.size()) chk(name, 32'(wcyc[idx]), 32'(exp));
    else chk(name, 32'hDEAD, 32'(exp));
  endtask

  task automatic model_reset();
    m_phase = 0; m_grant = 0; m_next = 0; m_sent = 0;
    m_frames = 0; m_drops = 0; m_truncs = 0;
  endtask

  // One clock cycle: drive at negedge, compare, pop at posedge, advance model.
  task automatic step();
    logic [9:0] head;
    logic [N-1:0] exp_rd, pops;
    logic exp_wr, exp_sof, exp_eof;
    logic [7:0] exp_data;
    int n_phase, n_grant, n_next, n_sent, n_frames, n_drops, n_truncs, cand;
    full = full_v;
    for (int i = 0; i < N; i++) begin
      if (q[i].size() > 0) begin
        head = q[i][0];
        in_empty[i] = 1'b0; in_sof[i] = head[9]; in_eof[i] = head[8];
        in_dout[i*W +: W] = head[7:0];
      end else begin
        in_empty[i] = 1'b1; in_sof[i] = 1'($urandom); in_eof[i] = 1'($urandom);
        in_dout[i*W +: W] = 8'($urandom);
      end
    end
    #1;
    exp_rd = '0; exp_wr = 1'b0; exp_sof = 1'b0; exp_eof = 1'b0; exp_data = 8'h00;
    n_phase = m_phase; n_grant = m_grant; n_next = m_next; n_sent = m_sent;
    n_frames = m_frames; n_drops = m_drops; n_truncs = m_truncs;
    if (m_phase == 0) begin
      cand = -1;
      for (int k = 0; k < N; k++)
        if (cand < 0 && q[(m_next + k) % N].size() > 0) cand = (m_next + k) % N;
      if (cand >= 0) begin
        head = q[cand][0];
        if (head[9]) begin n_grant = cand; n_sent = 0; n_phase = 1; end
        else begin exp_rd[cand] = 1'b1; n_drops = sat(m_drops); end
      end
    end else if (m_phase == 1) begin
      if (q[m_grant].size() > 0 && !full_v) begin
        head = q[m_grant][0];
        exp_rd[m_grant] = 1'b1; exp_wr = 1'b1; exp_data = head[7:0];
        exp_sof = head[9] && (m_sent == 0);
        exp_eof = head[8] || (m_sent == MF - 1);
        n_sent = m_sent + 1;
        if (head[8]) begin
          n_frames = sat(m_frames); n_next = (m_grant + 1) % N; n_phase = 0;
        end else if (m_sent == MF - 1) begin
          n_frames = sat(m_frames); n_truncs = sat(m_truncs); n_phase = 2;
        end
      end
    end else begin
      if (q[m_grant].size() > 0) begin
        head = q[m_grant][0];
        exp_rd[m_grant] = 1'b1;
        if (head[8]) begin n_next = (m_grant + 1) % N; n_phase = 0; end
      end
    end
    chk("in_rd_en", 32'(in_rd_en), 32'(exp_rd));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    chk("wr_sof", 32'(wr_sof), 32'(exp_sof));
    chk("wr_eof", 32'(wr_eof), 32'(exp_eof));
    chk("data_din", 32'(data_din), 32'(exp_data));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("frame_count", 32'(frame_count), 32'(m_frames));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("trunc_count", 32'(trunc_count), 32'(m_truncs));
    if (wr_en) begin
      wlog.push_back({wr_sof, wr_eof, data_din});
      wcyc.push_back(cyc);
    end
    pops = in_rd_en;
    @(posedge clock);
    for (int i = 0; i < N; i++)
      if (pops[i] && q[i].size() > 0) head = q[i].pop_front();
    m_phase = n_phase; m_grant = n_grant; m_next = n_next; m_sent = n_sent;
    m_frames = n_frames; m_drops = n_drops; m_truncs = n_truncs;
    cyc++;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < N; i++) begin q[i].delete(); pend[i].delete(); end
    in_empty = '1; full_v = 1'b0; full = 1'b0;
    model_reset();
    #1;
    chk("rst_in_rd_en", 32'(in_rd_en), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_sof", 32'(wr_sof), 32'd0);
    chk("rst_wr_eof", 32'(wr_eof), 32'd0);
    chk("rst_data_din", 32'(data_din), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_trunc_count", 32'(trunc_count), 32'd0);
    step(); step();
    reset = 1'b0;
    wlog.delete(); wcyc.delete();
  endtask

  // Random frame generator feeding the source FIFOs a byte at a time.
  task automatic feed(input bit gen);
    int len;
    for (int i = 0; i < N; i++) begin
      if (gen && pend[i].size() == 0 && $urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 5) == 0) begin
          pend[i].push_back({1'b0, 1'($urandom), 8'($urandom)});
        end else begin
          len = int'($urandom_range(1, 7));
          for (int b = 0; b < len; b++)
            pend[i].push_back({(b == 0) ? 1'b1 : ($urandom_range(0, 7) == 0),
                               (b == len - 1), 8'($urandom)});
        end
      end
      if (pend[i].size() > 0 && (!gen || $urandom_range(0, 1) == 1))
        q[i].push_back(pend[i].pop_front());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, failed=%0d", failed);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit done;
    @(negedge clock);

    // Single 3-byte frame from source 0.
    do_reset();
    step();
    c0 = cyc;
    q[0].push_back(10'h2AA); q[0].push_back(10'h0BB); q[0].push_back(10'h1CC);
    repeat (5) step();
    chk_log("t1_byte0", 0, 10'h2AA);
    chk_log("t1_byte1", 1, 10'h0BB);
    chk_log("t1_byte2", 2, 10'h1CC);
    chk("t1_nwrites", 32'(wlog.size()), 32'd3);
    chk_cyc("t1_first_cycle", 0, c0 + 1);
    chk_cyc("t1_last_cycle", 2, c0 + 3);
    chk("t1_frames", 32'(frame_count), 32'd1);

    // Round-robin between sources 0 and 1, two 2-byte frames each.
    do_reset();
    c0 = cyc;
    q[0].push_back(10'h211); q[0].push_back(10'h112);
    q[0].push_back(10'h213); q[0].push_back(10'h114);
    q[1].push_back(10'h221); q[1].push_back(10'h122);
    q[1].push_back(10'h223); q[1].push_back(10'h124);
    repeat (14) step();
    chk_log("rr_0", 0, 10'h211); chk_log("rr_1", 1, 10'h112);
    chk_log("rr_2", 2, 10'h221); chk_log("rr_3", 3, 10'h122);
    chk_log("rr_4", 4, 10'h213); chk_log("rr_5", 5, 10'h114);
    chk_log("rr_6", 6, 10'h223); chk_log("rr_7", 7, 10'h124);
    chk_cyc("rr_cyc2", 2, c0 + 4);
    chk_cyc("rr_cyc4", 4, c0 + 7);
    chk_cyc("rr_cyc7", 7, c0 + 11);
    chk("rr_frames", 32'(frame_count), 32'd4);

    // Backpressure for 5 cycles mid-frame.
    do_reset();
    c0 = cyc;
    q[0].push_back(10'h231); q[0].push_back(10'h032);
    q[0].push_back(10'h033); q[0].push_back(10'h134);
    repeat (3) step();
    full_v = 1'b1;
    repeat (5) step();
    full_v = 1'b0;
    repeat (3) step();
    chk_log("bp_0", 0, 10'h231); chk_log("bp_1", 1, 10'h032);
    chk_log("bp_2", 2, 10'h033); chk_log("bp_3", 3, 10'h134);
    chk("bp_nwrites", 32'(wlog.size()), 32'd4);
    chk_cyc("bp_resume_cycle", 2, c0 + 8);
    chk("bp_trunc", 32'(trunc_count), 32'd0);

    // Junk heads on source 1 ahead of a valid frame.
    do_reset();
    q[1].push_back(10'h051); q[1].push_back(10'h052);
    q[1].push_back(10'h253); q[1].push_back(10'h154);
    repeat (6) step();
    chk("junk_drops", 32'(drop_count), 32'd2);
    chk_log("junk_0", 0, 10'h253); chk_log("junk_1", 1, 10'h154);
    chk("junk_nwrites", 32'(wlog.size()), 32'd2);

    // Truncation of a 7-byte frame with MAX_FRAME=4.
    do_reset();
    q[0].push_back(10'h261);
    for (int b = 2; b <= 6; b++) q[0].push_back(10'(8'h60 + b));
    q[0].push_back(10'h167);
    q[1].push_back(10'h271); q[1].push_back(10'h172);
    repeat (8) step();
    chk("tr_frames_a", 32'(frame_count), 32'd1);
    chk("tr_trunc", 32'(trunc_count), 32'd1);
    chk("tr_nwrites_a", 32'(wlog.size()), 32'd4);
    chk("tr_src0_drained", 32'(q[0].size()), 32'd0);
    repeat (4) step();
    chk_log("tr_0", 0, 10'h261); chk_log("tr_3", 3, 10'h164);
    chk_log("tr_4", 4, 10'h271); chk_log("tr_5", 5, 10'h172);
    chk("tr_frames_b", 32'(frame_count), 32'd2);

    // Reset mid-transfer after two bytes (counters are non-zero here).
    q[0].push_back(10'h281); q[0].push_back(10'h082);
    q[0].push_back(10'h083); q[0].push_back(10'h184);
    repeat (3) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    do_reset();

    // Randomized traffic with random backpressure.
    for (int n = 0; n < 3000; n++) begin
      feed(1'b1);
      full_v = ($urandom_range(0, 3) == 0);
      step();
    end
    full_v = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      done = (m_phase == 0);
      for (int i = 0; i < N; i++)
        if (q[i].size() > 0 || pend[i].size() > 0) done = 1'b0;
      if (!done) begin
        feed(1'b0);
        step();
      end
    end
    chk("random_drain_done", 32'(done), 32'd1);
    chk("random_busy_end", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
